// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the frame buffer arbiter.
// Phase encoding matches the externally visible 'phase' port.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_LOAD    = 2'd1,
    PH_SOBEL   = 2'd2,
    PH_DISPLAY = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_LD    = 3'd1,
    REQ_SB_RD = 3'd2,
    REQ_SB_WR = 3'd3,
    REQ_VGA   = 3'd4
  } req_id_e;

  // Number of pixels in one image; also the base of the output image.
  function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Row/column to linear BRAM address translation.
// out_sel picks the output image (based at one full frame) instead of the
// input image (based at 0). oob flags coordinates outside the image.
module fb_addr_gen
  import fb_arb_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 20
) (
  input  logic [15:0]       row,
  input  logic [15:0]       col,
  input  logic              out_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  localparam int unsigned       FRAME_PIX_L = frame_pix(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] WIDTH_A     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_BASE_A  = ADDR_W'(FRAME_PIX_L);

  logic [ADDR_W-1:0] lin_s;

  // Linear offset inside the image plus the selected image base.
  always_comb begin
    oob   = (row >= 16'(IMG_H)) || (col >= 16'(IMG_W));
    lin_s = ADDR_W'(row) * WIDTH_A + ADDR_W'(col);
    if (out_sel) begin
      addr = lin_s + OUT_BASE_A;
    end else begin
      addr = lin_s;
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: owns the load -> Sobel -> display phase machine and
// shares the single-port frame BRAM among loader, Sobel engine and VGA.
// Grants are decided combinationally from the sampled requests; acks and BRAM
// strobes are registered one cycle later; read data returns one further cycle
// later together with the requester's valid.
// Optional feature macro: FB_ARB_VGA_PRIORITY_EN -- VGA is also served during
// the Sobel phase with strict priority over the Sobel engine.
module frame_buffer_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_req,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  input  logic              sb_rd_req,
  input  logic [15:0]       sb_rd_row,
  input  logic [15:0]       sb_rd_col,
  output logic              sb_rd_ack,
  output logic              sb_rd_valid,
  input  logic              sb_wr_req,
  input  logic [15:0]       sb_wr_row,
  input  logic [15:0]       sb_wr_col,
  input  logic [7:0]        sb_wr_data,
  output logic              sb_wr_ack,
  input  logic              sb_done,
  input  logic              vga_req,
  input  logic [15:0]       vga_row,
  input  logic [15:0]       vga_col,
  output logic              vga_ack,
  output logic              vga_valid,
  output logic [7:0]        rd_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  input  logic [7:0]        bram_rdata,
  output logic              all_loaded,
  output logic              sobel_ready,
  output logic [1:0]        phase
);

  localparam int unsigned       FRAME_PIX_L = frame_pix(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_PIX_A  = ADDR_W'(FRAME_PIX_L - 1);
  localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_A      = ADDR_W'(0);

  phase_e            state_r, state_nx_s;
  req_id_e           grant_s, sb_pick_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
  logic              all_loaded_r, all_loaded_nx_s;
  logic              sobel_ready_r, sobel_ready_nx_s;
  logic              pref_wr_r, pref_wr_nx_s;

  logic [15:0]       ag_row_s, ag_col_s;
  logic              ag_out_s, ag_oob_s;
  logic [ADDR_W-1:0] ag_addr_s;

  logic              ld_ack_r, sb_rd_ack_r, sb_wr_ack_r, vga_ack_r;
  logic              bram_en_r, bram_we_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic [7:0]        bram_wdata_r;
  logic              rd_sb_p1_r, rd_vga_p1_r, oob_p1_r;
  logic              sb_rd_valid_r, vga_valid_r, oob_p2_r;

  // Sobel round-robin choice: on contention the side not granted last wins.
  always_comb begin
    sb_pick_s = REQ_NONE;
    if (sb_rd_req && sb_wr_req) begin
      sb_pick_s = pref_wr_r ? REQ_SB_WR : REQ_SB_RD;
    end else if (sb_rd_req) begin
      sb_pick_s = REQ_SB_RD;
    end else if (sb_wr_req) begin
      sb_pick_s = REQ_SB_WR;
    end else begin
      sb_pick_s = REQ_NONE;
    end
  end

  // Grant selection: only the requesters allowed in the current phase compete.
  always_comb begin
    grant_s = REQ_NONE;
    case (state_r)
      PH_IDLE: grant_s = REQ_NONE;
      PH_LOAD: begin
        if (ld_req) begin
          grant_s = REQ_LD;
        end else begin
          grant_s = REQ_NONE;
        end
      end
      PH_SOBEL: begin
`ifdef FB_ARB_VGA_PRIORITY_EN
        if (vga_req) begin
          grant_s = REQ_VGA;
        end else begin
          grant_s = sb_pick_s;
        end
`else
        grant_s = sb_pick_s;
`endif
      end
      PH_DISPLAY: begin
        if (vga_req) begin
          grant_s = REQ_VGA;
        end else begin
          grant_s = REQ_NONE;
        end
      end
      default: grant_s = REQ_NONE;
    endcase
  end

  // Route the granted requester's coordinates to the address generator.
  always_comb begin
    ag_row_s = 16'd0;
    ag_col_s = 16'd0;
    ag_out_s = 1'b0;
    case (grant_s)
      REQ_SB_RD: begin
        ag_row_s = sb_rd_row;
        ag_col_s = sb_rd_col;
        ag_out_s = 1'b0;
      end
      REQ_SB_WR: begin
        ag_row_s = sb_wr_row;
        ag_col_s = sb_wr_col;
        ag_out_s = 1'b1;
      end
      REQ_VGA: begin
        ag_row_s = vga_row;
        ag_col_s = vga_col;
        ag_out_s = 1'b1;
      end
      default: begin
        ag_row_s = 16'd0;
        ag_col_s = 16'd0;
        ag_out_s = 1'b0;
      end
    endcase
  end

  fb_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .row    (ag_row_s),
    .col    (ag_col_s),
    .out_sel(ag_out_s),
    .addr   (ag_addr_s),
    .oob    (ag_oob_s)
  );

  // Round-robin pointer moves only on Sobel grants; VGA grants leave it alone.
  always_comb begin
    pref_wr_nx_s = pref_wr_r;
    if (grant_s == REQ_SB_RD) begin
      pref_wr_nx_s = 1'b1;
    end else if (grant_s == REQ_SB_WR) begin
      pref_wr_nx_s = 1'b0;
    end else begin
      pref_wr_nx_s = pref_wr_r;
    end
  end

  // Phase machine next state, load counter and phase flags.
  always_comb begin
    state_nx_s       = state_r;
    cnt_nx_s         = cnt_r;
    all_loaded_nx_s  = all_loaded_r;
    sobel_ready_nx_s = sobel_ready_r;
    case (state_r)
      PH_IDLE, PH_DISPLAY: begin
        if (start) begin
          state_nx_s       = PH_LOAD;
          cnt_nx_s         = ZERO_A;
          all_loaded_nx_s  = 1'b0;
          sobel_ready_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      PH_LOAD: begin
        if (grant_s == REQ_LD) begin
          cnt_nx_s = cnt_r + ONE_A;
          if (cnt_r == LAST_PIX_A) begin
            state_nx_s      = PH_SOBEL;
            all_loaded_nx_s = 1'b1;
          end else begin
            state_nx_s = PH_LOAD;
          end
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      PH_SOBEL: begin
        if (sb_done) begin
          state_nx_s       = PH_DISPLAY;
          sobel_ready_nx_s = 1'b1;
        end else begin
          state_nx_s = PH_SOBEL;
        end
      end
      default: state_nx_s = PH_IDLE;
    endcase
  end

  // Phase/control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= PH_IDLE;
      cnt_r         <= ZERO_A;
      all_loaded_r  <= 1'b0;
      sobel_ready_r <= 1'b0;
      pref_wr_r     <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      all_loaded_r  <= all_loaded_nx_s;
      sobel_ready_r <= sobel_ready_nx_s;
      pref_wr_r     <= pref_wr_nx_s;
    end
  end

  // Registered acks, BRAM strobes and the two-stage read-valid pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ack_r      <= 1'b0;
      sb_rd_ack_r   <= 1'b0;
      sb_wr_ack_r   <= 1'b0;
      vga_ack_r     <= 1'b0;
      bram_en_r     <= 1'b0;
      bram_we_r     <= 1'b0;
      bram_addr_r   <= ZERO_A;
      bram_wdata_r  <= 8'd0;
      rd_sb_p1_r    <= 1'b0;
      rd_vga_p1_r   <= 1'b0;
      oob_p1_r      <= 1'b0;
      sb_rd_valid_r <= 1'b0;
      vga_valid_r   <= 1'b0;
      oob_p2_r      <= 1'b0;
    end else begin
      ld_ack_r      <= (grant_s == REQ_LD);
      sb_rd_ack_r   <= (grant_s == REQ_SB_RD);
      sb_wr_ack_r   <= (grant_s == REQ_SB_WR);
      vga_ack_r     <= (grant_s == REQ_VGA);
      rd_sb_p1_r    <= (grant_s == REQ_SB_RD);
      rd_vga_p1_r   <= (grant_s == REQ_VGA);
      oob_p1_r      <= ag_oob_s && ((grant_s == REQ_SB_RD) || (grant_s == REQ_VGA));
      sb_rd_valid_r <= rd_sb_p1_r;
      vga_valid_r   <= rd_vga_p1_r;
      oob_p2_r      <= oob_p1_r;
      case (grant_s)
        REQ_LD: begin
          bram_en_r    <= 1'b1;
          bram_we_r    <= 1'b1;
          bram_addr_r  <= cnt_r;
          bram_wdata_r <= ld_data;
        end
        REQ_SB_WR: begin
          bram_en_r    <= !ag_oob_s;
          bram_we_r    <= !ag_oob_s;
          bram_addr_r  <= ag_oob_s ? ZERO_A : ag_addr_s;
          bram_wdata_r <= ag_oob_s ? 8'd0 : sb_wr_data;
        end
        REQ_SB_RD, REQ_VGA: begin
          bram_en_r    <= !ag_oob_s;
          bram_we_r    <= 1'b0;
          bram_addr_r  <= ag_oob_s ? ZERO_A : ag_addr_s;
          bram_wdata_r <= 8'd0;
        end
        default: begin
          bram_en_r    <= 1'b0;
          bram_we_r    <= 1'b0;
          bram_addr_r  <= ZERO_A;
          bram_wdata_r <= 8'd0;
        end
      endcase
    end
  end

  assign ld_ack      = ld_ack_r;
  assign sb_rd_ack   = sb_rd_ack_r;
  assign sb_wr_ack   = sb_wr_ack_r;
  assign vga_ack     = vga_ack_r;
  assign sb_rd_valid = sb_rd_valid_r;
  assign vga_valid   = vga_valid_r;
  assign bram_en     = bram_en_r;
  assign bram_we     = bram_we_r;
  assign bram_addr   = bram_addr_r;
  assign bram_wdata  = bram_wdata_r;
  assign all_loaded  = all_loaded_r;
  assign sobel_ready = sobel_ready_r;
  assign phase       = state_r;
  // BRAM output is only forwarded for in-range reads; otherwise zero.
  assign rd_data     = ((sb_rd_valid_r || vga_valid_r) && !oob_p2_r) ? bram_rdata : 8'd0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter on a 4x3 image.
module tb_frame_buffer_arbiter;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 5;
  localparam int NPIX = W * H;

  logic clk, reset, start, ld_req, ld_ack;
  logic [7:0] ld_data;
  logic sb_rd_req, sb_rd_ack, sb_rd_valid;
  logic [15:0] sb_rd_row, sb_rd_col;
  logic sb_wr_req, sb_wr_ack;
  logic [15:0] sb_wr_row, sb_wr_col;
  logic [7:0] sb_wr_data;
  logic sb_done;
  logic vga_req, vga_ack, vga_valid;
  logic [15:0] vga_row, vga_col;
  logic [7:0] rd_data;
  logic bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0] bram_wdata, bram_rdata;
  logic all_loaded, sobel_ready;
  logic [1:0] phase;

  frame_buffer_arbiter #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_req(ld_req), .ld_data(ld_data), .ld_ack(ld_ack),
    .sb_rd_req(sb_rd_req), .sb_rd_row(sb_rd_row), .sb_rd_col(sb_rd_col),
    .sb_rd_ack(sb_rd_ack), .sb_rd_valid(sb_rd_valid),
    .sb_wr_req(sb_wr_req), .sb_wr_row(sb_wr_row), .sb_wr_col(sb_wr_col),
    .sb_wr_data(sb_wr_data), .sb_wr_ack(sb_wr_ack), .sb_done(sb_done),
    .vga_req(vga_req), .vga_row(vga_row), .vga_col(vga_col),
    .vga_ack(vga_ack), .vga_valid(vga_valid), .rd_data(rd_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .all_loaded(all_loaded), .sobel_ready(sobel_ready), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM with one-cycle synchronous read.
  logic [7:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 8'd0;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else bram_rdata <= mem[bram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_in [NPIX];
  logic [7:0] ref_out [NPIX];

  typedef struct {
    logic          is_wr;
    logic [15:0]   row;
    logic [15:0]   col;
    logic [7:0]    wdata;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_rd;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 1'b0; ld_req = 1'b0; ld_data = 8'd0; sb_done = 1'b0;
    sb_rd_req = 1'b0; sb_rd_row = 16'd0; sb_rd_col = 16'd0;
    sb_wr_req = 1'b0; sb_wr_row = 16'd0; sb_wr_col = 16'd0; sb_wr_data = 8'd0;
    vga_req = 1'b0; vga_row = 16'd0; vga_col = 16'd0;
  endtask

  function automatic logic [63:0] outs_all();
    return {31'd0, ld_ack, sb_rd_ack, sb_rd_valid, sb_wr_ack, vga_ack, vga_valid,
            rd_data, bram_en, bram_we, bram_addr, bram_wdata, all_loaded, sobel_ready, phase};
  endfunction

  logic last_wr, exp_rd, exp_wr, pend_v, inr;
  logic [7:0] pend_d, wd;
  int r, c;

  initial begin
    reset = 1'b1;
    clr();
    for (int i = 0; i < NPIX; i++) begin
      ref_in[i]  = 8'(i);
      ref_out[i] = 8'd0;
    end
    //          is_wr row     col     wdata   en    addr   rdata
    vecs[0] = '{1'b0, 16'd2, 16'd3, 8'h00, 1'b1, 5'd11, 8'd11};
    vecs[1] = '{1'b0, 16'd0, 16'd0, 8'h00, 1'b1, 5'd0,  8'd0};
    vecs[2] = '{1'b0, 16'd1, 16'd1, 8'h00, 1'b1, 5'd5,  8'd5};
    vecs[3] = '{1'b0, 16'd3, 16'd0, 8'h00, 1'b0, 5'd0,  8'd0};
    vecs[4] = '{1'b0, 16'd0, 16'd4, 8'h00, 1'b0, 5'd0,  8'd0};
    vecs[5] = '{1'b1, 16'd1, 16'd2, 8'h55, 1'b1, 5'd18, 8'd0};
    vecs[6] = '{1'b1, 16'd2, 16'd3, 8'hAA, 1'b1, 5'd23, 8'd0};
    vecs[7] = '{1'b1, 16'd3, 16'd3, 8'h77, 1'b0, 5'd0,  8'd0};
    vecs[8] = '{1'b1, 16'd0, 16'd0, 8'h11, 1'b1, 5'd12, 8'd0};
    vecs[9] = '{1'b0, 16'd2, 16'd0, 8'h00, 1'b1, 5'd8,  8'd8};

    cyc(); cyc();
    chk("reset_outs", outs_all(), 64'd0);
    reset = 1'b0;
    cyc();
    chk("idle_phase", 64'(phase), 64'd0);

    // start with a loader request in the same cycle: IDLE never grants it
    start = 1'b1; ld_req = 1'b1; ld_data = 8'hEE;
    cyc();
    clr();
    chk("start_to_load", 64'(phase), 64'd1);
    chk("idle_ld_noack", 64'(ld_ack), 64'd0);

    // 12 back-to-back loads; other requests, a stray start and sb_done are ignored
    for (int i = 0; i < NPIX; i++) begin
      ld_req = 1'b1; ld_data = 8'(i);
      sb_rd_req = 1'b1; sb_wr_req = 1'b1; vga_req = 1'b1;
      start = (i == 5); sb_done = (i == 3);
      cyc();
      chk("ld_ack", 64'(ld_ack), 64'd1);
      chk("ld_strobe", 64'({bram_en, bram_we}), 64'd3);
      chk("ld_addr", 64'(bram_addr), 64'(i));
      chk("ld_wdata", 64'(bram_wdata), 64'(i));
      chk("ld_other_acks", 64'({sb_rd_ack, sb_wr_ack, vga_ack}), 64'd0);
      chk("ld_all_loaded", 64'(all_loaded), 64'(i == NPIX - 1));
      chk("ld_phase", 64'(phase), (i == NPIX - 1) ? 64'd2 : 64'd1);
    end
    clr();

    // Round robin with both Sobel ports held: RD,WR,RD,WR
    sb_rd_req = 1'b1;
    sb_wr_req = 1'b1; sb_wr_row = 16'd1; sb_wr_col = 16'd2; sb_wr_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_acks", 64'({sb_rd_ack, sb_wr_ack}), (i % 2 == 0) ? 64'd2 : 64'd1);
      chk("rr_we", 64'(bram_we), 64'(i % 2));
      chk("rr_addr", 64'(bram_addr), (i % 2 == 0) ? 64'd0 : 64'd18);
    end
    last_wr = 1'b1;
    ref_out[1 * W + 2] = 8'h55;
    clr();
    cyc(); cyc(); cyc();

    // Table of single accesses: ack/strobes on N+1, read data on N+2
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        sb_wr_req = 1'b1; sb_wr_row = vecs[i].row; sb_wr_col = vecs[i].col;
        sb_wr_data = vecs[i].wdata;
      end else begin
        sb_rd_req = 1'b1; sb_rd_row = vecs[i].row; sb_rd_col = vecs[i].col;
      end
      cyc();
      clr();
      chk("vec_ack", 64'({sb_rd_ack, sb_wr_ack}), vecs[i].is_wr ? 64'd1 : 64'd2);
      chk("vec_en", 64'(bram_en), 64'(vecs[i].exp_en));
      chk("vec_we", 64'(bram_we), 64'(vecs[i].is_wr & vecs[i].exp_en));
      if (vecs[i].exp_en) chk("vec_addr", 64'(bram_addr), 64'(vecs[i].exp_addr));
      chk("vec_early_valid", 64'(sb_rd_valid), 64'd0);
      cyc();
      chk("vec_valid", 64'(sb_rd_valid), 64'(!vecs[i].is_wr));
      if (!vecs[i].is_wr) chk("vec_rdata", 64'(rd_data), 64'(vecs[i].exp_rd));
      if (vecs[i].is_wr && vecs[i].exp_en)
        ref_out[int'(vecs[i].row) * W + int'(vecs[i].col)] = vecs[i].wdata;
      last_wr = vecs[i].is_wr;
    end
    cyc();

    // VGA and Sobel read together during the Sobel phase
    vga_req = 1'b1; vga_row = 16'd1; vga_col = 16'd2;
    sb_rd_req = 1'b1; sb_rd_row = 16'd0; sb_rd_col = 16'd1;
    cyc();
`ifdef FB_ARB_VGA_PRIORITY_EN
    chk("vgap_first", 64'({vga_ack, sb_rd_ack}), 64'd2);
    vga_req = 1'b0;
    cyc();
    sb_rd_req = 1'b0;
    chk("vgap_second", 64'({vga_ack, sb_rd_ack}), 64'd1);
    chk("vgap_vvalid", 64'(vga_valid), 64'd1);
    chk("vgap_vdata", 64'(rd_data), 64'(ref_out[1 * W + 2]));
    cyc();
    chk("vgap_svalid", 64'(sb_rd_valid), 64'd1);
    chk("vgap_sdata", 64'(rd_data), 64'(ref_in[1]));
`else
    chk("vga_blocked_a", 64'({vga_ack, sb_rd_ack}), 64'd1);
    sb_rd_req = 1'b0;
    cyc();
    chk("vga_blocked_b", 64'(vga_ack), 64'd0);
    chk("vga_blk_svalid", 64'(sb_rd_valid), 64'd1);
    chk("vga_blk_sdata", 64'(rd_data), 64'(ref_in[1]));
    cyc();
    chk("vga_blocked_c", 64'(vga_ack), 64'd0);
`endif
    last_wr = 1'b0;
    clr();
    cyc(); cyc();

    // Randomized Sobel traffic against the reference model
    pend_v = 1'b0; pend_d = 8'd0;
    for (int k = 0; k < 80; k++) begin
      sb_rd_req = 1'($urandom_range(0, 1));
      sb_wr_req = 1'($urandom_range(0, 1));
      sb_rd_row = 16'($urandom_range(0, 3)); sb_rd_col = 16'($urandom_range(0, 4));
      sb_wr_row = 16'($urandom_range(0, 3)); sb_wr_col = 16'($urandom_range(0, 4));
      wd = 8'($urandom); sb_wr_data = wd;
      if (sb_rd_req && sb_wr_req) exp_wr = !last_wr;
      else exp_wr = sb_wr_req;
      exp_rd = sb_rd_req && !exp_wr;
      if (exp_rd || exp_wr) last_wr = exp_wr;
      cyc();
      chk("rnd_acks", 64'({sb_rd_ack, sb_wr_ack}), 64'({exp_rd, exp_wr}));
      chk("rnd_valid", 64'(sb_rd_valid), 64'(pend_v));
      if (pend_v) chk("rnd_rdata", 64'(rd_data), 64'(pend_d));
      r = int'(sb_wr_row); c = int'(sb_wr_col);
      inr = (r < H) && (c < W);
      if (exp_wr) begin
        chk("rnd_wr_en", 64'({bram_en, bram_we}), inr ? 64'd3 : 64'd0);
        if (inr) begin
          chk("rnd_wr_addr", 64'(bram_addr), 64'(NPIX + r * W + c));
          ref_out[r * W + c] = wd;
        end
      end
      r = int'(sb_rd_row); c = int'(sb_rd_col);
      pend_v = exp_rd;
      pend_d = ((r < H) && (c < W)) ? ref_in[r * W + c] : 8'd0;
    end
    clr();
    cyc();
    chk("rnd_valid_last", 64'(sb_rd_valid), 64'(pend_v));
    if (pend_v) chk("rnd_rdata_last", 64'(rd_data), 64'(pend_d));
    cyc();

    // Sobel done -> display phase
    sb_done = 1'b1;
    cyc();
    sb_done = 1'b0;
    chk("done_phase", 64'(phase), 64'd3);
    chk("done_ready", 64'(sobel_ready), 64'd1);

    // Scan the whole output image (plus one out-of-range pixel) through VGA
    pend_v = 1'b0; pend_d = 8'd0;
    for (int p = 0; p <= NPIX; p++) begin
      vga_req = 1'b1; vga_row = 16'(p / W); vga_col = 16'(p % W);
      sb_rd_req = 1'b1;
      cyc();
      chk("vga_ack", 64'(vga_ack), 64'd1);
      chk("disp_sb_noack", 64'(sb_rd_ack), 64'd0);
      chk("vga_valid", 64'(vga_valid), 64'(pend_v));
      if (pend_v) chk("vga_rdata", 64'(rd_data), 64'(pend_d));
      pend_v = 1'b1;
      pend_d = (p < NPIX) ? ref_out[p] : 8'd0;
    end
    clr();
    cyc();
    chk("vga_valid_last", 64'(vga_valid), 64'd1);
    chk("vga_oob_rdata", 64'(rd_data), 64'd0);
    cyc();

    // Restart, then reset in the middle of loading
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_phase", 64'(phase), 64'd1);
    chk("restart_flags", 64'({all_loaded, sobel_ready}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      ld_req = 1'b1; ld_data = 8'(100 + i);
      cyc();
    end
    chk("pre_reset_addr", 64'(bram_addr), 64'd4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", outs_all(), 64'd0);
    cyc();
    reset = 1'b0;
    ld_req = 1'b0;
    cyc();
    chk("post_reset_outs", outs_all(), 64'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ld_req = 1'b1; ld_data = 8'hC3;
    cyc();
    clr();
    chk("reload_ack", 64'(ld_ack), 64'd1);
    chk("reload_addr", 64'(bram_addr), 64'd0);
    chk("reload_wdata", 64'(bram_wdata), 64'hC3);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Sequences and shares the single-port grayscale frame BRAM among the pixel loader (rgb2gray output), the Sobel engine (read and write) and the VGA scanner. Owns the frame phase state machine (load → Sobel → display) and issues `all_loaded` and `sobel_ready` to the rest of the pipeline. It translates requester (row, col) coordinates into linear BRAM addresses. Input and output images live in one BRAM: input at base 0, output at base IMG_W*IMG_H.

## Interface
- IMG_W, 640, image width in pixels
- IMG_H, 480, image height in pixels
- ADDR_W, 20, BRAM address width; must satisfy 2^ADDR_W ≥ 2*IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin loading a new frame
- ld_req / ld_data  in  1 / 8  loader write request / gray pixel (address implicit, sequential)
- ld_ack  out  1  loader write accepted
- sb_rd_req, sb_rd_row, sb_rd_col  in  1,16,16  Sobel read of input image
- sb_rd_ack / sb_rd_valid  out  1 / 1  read accepted / rd_data valid for Sobel
- sb_wr_req, sb_wr_row, sb_wr_col, sb_wr_data  in  1,16,16,8  Sobel write of output image
- sb_wr_ack  out  1  write accepted
- sb_done  in  1  pulse: Sobel finished frame
- vga_req, vga_row, vga_col  in  1,16,16  VGA read of output image
- vga_ack / vga_valid  out  1 / 1  read accepted / rd_data valid for VGA
- rd_data  out  8  shared read data
- bram_en, bram_we  out  1,1  BRAM strobes
- bram_addr / bram_wdata  out  ADDR_W / 8  BRAM address / write data
- bram_rdata  in  8  BRAM read data (1-cycle synchronous)
- all_loaded, sobel_ready  out  1,1  phase flags
- phase  out  2  current state encoding

## Operation
- States: IDLE(0) → LOAD(1) → SOBEL(2) → DISPLAY(3).
- IDLE: start → LOAD, load counter cleared.
- LOAD: only ld_req granted; writes ld_data at load counter, counter +1 per ack. Ack of write at counter = IMG_W*IMG_H−1 → all_loaded=1, state SOBEL.
- SOBEL: sb_rd/sb_wr round-robin (last-granted pointer, reset favours read). sb_done → DISPLAY, sobel_ready=1.
- DISPLAY: vga_req only. start → LOAD, clears all_loaded, sobel_ready, counter.
- start outside IDLE/DISPLAY ignored; sb_done outside SOBEL ignored; requests not allowed in current state never acked.
- Address: input = row*IMG_W+col; output = IMG_W*IMG_H + row*IMG_W+col.
- Out-of-range (row ≥ IMG_H or col ≥ IMG_W): request still acked, bram_en=0; read returns rd_data=0 with valid asserted; write dropped.
- Requester holds req and operands until ack; ack is one-cycle pulse; req held after ack means a new access.

## Timing
- Arbitration on cycle N (req sampled) → registered ack, bram_en/we/addr/wdata on N+1.
- Read: rd_data with sb_rd_valid/vga_valid on N+2; latency 2, throughput 1 access/cycle.
- Phase transitions take effect the cycle after the triggering ack/pulse; no grant in the transition cycle's successor is lost — the new state's arbitration begins that cycle.
- Reset (any time, mid-access included): state IDLE, all outputs 0, counter 0, RR pointer to read, pending valids cancelled.

## Configuration
- FB_ARB_VGA_PRIORITY_EN defined: vga_req also granted in SOBEL with strict priority over Sobel (display of previous output during processing); Sobel RR pointer unchanged on VGA grants.
- Undefined: VGA served only in DISPLAY.

## Structure
- Package fb_arb_pkg: phase enum, requester-id enum (NONE, LD, SB_RD, SB_WR, VGA), FRAME_PIX function of IMG_W/IMG_H.
- Sub-module fb_addr_gen: combinational row/col → linear address with base select and out-of-range flag.

## Test plan
- IMG_W=4, IMG_H=3: start, 12 back-to-back ld_req, data 0..11 → addrs 0..11, all_loaded rises after 12th ack, phase=2.
- SOBEL, sb_rd and sb_wr both held 4 cycles → acks alternate RD,WR,RD,WR; sb_wr (1,2,data 0x55) → bram_addr 18, we=1.
- sb_rd (2,3) after load → rd_data=11, sb_rd_valid exactly 2 cycles after req sample.
- sb_rd (3,0) out of range → ack, bram_en=0, rd_data=0 valid.
- With macro: vga_req and sb_rd simultaneous in SOBEL → VGA acked first; without macro VGA never acked until sb_done.
- reset asserted mid-LOAD at counter 5 → all outputs 0 immediately; subsequent start reloads from address 0.
